// File: rtl/dram_ctrl.sv
// dram_ctrl: single-request DRAM controller driving a shared row/column A bus.
// Each request is latched, then: row select, RAS, column select, CAS, an
// optional CAS-latency wait for reads, precharge and a one-cycle response.
// Build option: define DRAM_OPEN_PAGE_EN to leave the row open after an access
// (OPEN state); a following request to the same row then starts at COL.
module dram_ctrl #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 11,
    parameter int CAS_LAT  = 1
) (
    input  logic                         CK,
    input  logic                         RSTn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
    input  logic [31:0]                  req_wdata,
    input  logic [3:0]                   req_wstrb,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         CSn,
    output logic                         RASn,
    output logic                         CASn,
    output logic [3:0]                   WEn,
    output logic [COL_BITS-1:0]          A,
    output logic [31:0]                  D,
    input  logic [31:0]                  Q
);

    localparam int AW = ROW_BITS + COL_BITS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_RAS  = 3'd2,
        S_COL  = 3'd3,
        S_CAS  = 3'd4,
        S_WAIT = 3'd5,
        S_PRE  = 3'd6
`ifdef DRAM_OPEN_PAGE_EN
        , S_OPEN = 3'd7
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rdy_en;
    logic [2:0]          wait_cnt;
    logic                last_wait;
    logic                accept;
    logic [ROW_BITS-1:0] req_row;
    logic [COL_BITS-1:0] req_col;
    logic                lat_write;
    logic [ROW_BITS-1:0] lat_row;
    logic [COL_BITS-1:0] lat_col;
    logic [31:0]         lat_wdata;
    logic [3:0]          lat_wstrb;
`ifdef DRAM_OPEN_PAGE_EN
    logic                open_new;
`endif

    assign req_row   = req_addr[AW-1:COL_BITS];
    assign req_col   = req_addr[COL_BITS-1:0];
    assign accept    = req_valid && req_ready;
    assign last_wait = (wait_cnt == 3'(CAS_LAT - 1));

    // State register; reset returns to IDLE and drops any latched request
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state sequencing of the access
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_ROW;
            S_ROW:  state_nxt = S_RAS;
            S_RAS:  state_nxt = S_COL;
            S_COL:  state_nxt = S_CAS;
`ifdef DRAM_OPEN_PAGE_EN
            S_CAS:  state_nxt = lat_write ? S_OPEN : S_WAIT;
            S_WAIT: if (last_wait) state_nxt = S_OPEN;
            // PRE is only reached on a row miss, so it goes straight to the new row
            S_PRE:  state_nxt = S_ROW;
            S_OPEN: if (accept) state_nxt = (req_row == lat_row) ? S_COL : S_PRE;
`else
            S_CAS:  state_nxt = lat_write ? S_PRE : S_WAIT;
            S_WAIT: if (last_wait) state_nxt = S_PRE;
            S_PRE:  state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pin and handshake decode from the current state and latched request
    always_comb begin
        CSn       = 1'b1;
        RASn      = 1'b1;
        CASn      = 1'b1;
        WEn       = 4'b1111;
        A         = '0;
        D         = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: req_ready = rdy_en;
            S_ROW: begin
                CSn = 1'b0;
                A   = COL_BITS'(lat_row);
            end
            S_RAS: begin
                CSn  = 1'b0;
                RASn = 1'b0;
                A    = COL_BITS'(lat_row);
            end
            S_COL, S_CAS: begin
                CSn  = 1'b0;
                RASn = 1'b0;
                CASn = (state == S_CAS) ? 1'b0 : 1'b1;
                A    = lat_col;
                if (lat_write) begin
                    WEn = ~lat_wstrb;
                    D   = lat_wdata;
                end
            end
            S_WAIT: begin
                CSn  = 1'b0;
                RASn = 1'b0;
                CASn = 1'b0;
                A    = lat_col;
            end
            S_PRE: begin
                CSn = 1'b0;
`ifndef DRAM_OPEN_PAGE_EN
                rsp_valid = 1'b1;
`endif
            end
`ifdef DRAM_OPEN_PAGE_EN
            S_OPEN: begin
                CSn       = 1'b0;
                RASn      = 1'b0;
                A         = COL_BITS'(lat_row);
                req_ready = 1'b1;
                rsp_valid = open_new;
            end
`endif
            default: ;
        endcase
    end

    // Control registers: ready enable after reset, CAS-latency counter
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            rdy_en   <= 1'b0;
            wait_cnt <= 3'd0;
        end else begin
            rdy_en <= 1'b1;
            if (state == S_CAS)       wait_cnt <= 3'd0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // Read data capture at the last WAIT edge; held across writes
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn)                          rsp_rdata <= 32'h0;
        else if (state == S_WAIT && last_wait) rsp_rdata <= Q;
    end

`ifdef DRAM_OPEN_PAGE_EN
    // Mark the first OPEN cycle so the completion pulse lasts one cycle
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) open_new <= 1'b0;
        else       open_new <= (state_nxt == S_OPEN) && (state != S_OPEN);
    end
`endif

    // Request latch; data path only, so it carries no reset
    always_ff @(posedge CK) begin
        if (accept) begin
            lat_write <= req_write;
            lat_row   <= req_row;
            lat_col   <= req_col;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Testbench for dram_ctrl: byte-addressable reference memory, latency model
// derived from the access sequence, behavioural DRAM device on the pins.
// Honours DRAM_OPEN_PAGE_EN when the same macro is defined for the bench.
`timescale 1ns/1ps
module tb_dram_ctrl;

    localparam int ROW_BITS = 11;
    localparam int COL_BITS = 11;
    localparam int CAS_LAT  = 1;
    localparam int AW       = ROW_BITS + COL_BITS;

    logic              CK = 1'b0;
    logic              RSTn = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_wstrb = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              CSn, RASn, CASn;
    logic [3:0]        WEn;
    logic [COL_BITS-1:0] A;
    logic [31:0]       D;
    logic [31:0]       Q = '0;

    always #5 CK = ~CK;

    dram_ctrl #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .CAS_LAT(CAS_LAT)) dut (
        .CK(CK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn), .A(A), .D(D), .Q(Q)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural DRAM device ----------------
    logic [31:0]         dev_mem [logic [AW-1:0]];
    logic [ROW_BITS-1:0] dev_row = '0;
    logic                prev_ras = 1'b1;
    logic                prev_cas = 1'b1;
    int                  rd_cnt = 0;
    logic [31:0]         rd_data = '0;

    always @(negedge CK) begin
        logic [AW-1:0] key;
        logic [31:0]   cur;
        if (!CSn && !RASn && prev_ras) dev_row = ROW_BITS'(A);
        if (!CSn && !CASn && prev_cas) begin
            key = {dev_row, A};
            cur = dev_mem.exists(key) ? dev_mem[key] : 32'h0;
            if (WEn != 4'b1111) begin
                for (int b = 0; b < 4; b++) if (!WEn[b]) cur[8*b +: 8] = D[8*b +: 8];
                dev_mem[key] = cur;
            end else begin
                rd_data = cur;
                rd_cnt  = CAS_LAT;
                Q       = $urandom;
            end
        end else if (rd_cnt > 0) begin
            rd_cnt--;
            Q = (rd_cnt == 0) ? rd_data : $urandom;
        end
        prev_ras = RASn | CSn;
        prev_cas = CASn;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } req_t;

    req_t                rq[$];
    logic [31:0]         ref_mem [logic [AW-1:0]];
    logic [31:0]         last_rd = 32'h0;
    bit                  pg_open = 1'b0;
    logic [ROW_BITS-1:0] pg_row = '0;
    int                  last_lat = 0;
    logic [COL_BITS-1:0] tr_a   [0:15];
    logic [3:0]          tr_wen [0:15];
    logic                tr_ras [0:15];
    logic                tr_cas [0:15];
    logic                tr_cs  [0:15];
    logic [31:0]         tr_d   [0:15];
    logic [3:0]          cas_wen = 4'h0;

    task automatic push(input logic w, input int row, input int col,
                        input logic [31:0] data, input logic [3:0] strb);
        req_t r;
        r.w    = w;
        r.addr = {ROW_BITS'(row), COL_BITS'(col)};
        r.data = data;
        r.strb = strb;
        rq.push_back(r);
    endtask

    // Drive the queued requests, one check per response against the model
    task automatic run(input bit hold, input int maxgap);
        int          n = rq.size();
        int          got = 0;
        int          cyc = 0;
        int          budget = n * 30 + 40;
        int          gap = 0;
        int          since_rsp = 0;
        int          exp_lat = 0;
        int          base;
        bit          busy = 1'b0;
        bit          cas_seen = 1'b0;
        req_t        cur;
        logic [31:0] exp_rd = 32'h0;
        logic [31:0] old;
        logic [ROW_BITS-1:0] row;
        while ((rq.size() > 0 || busy) && budget > 0) begin
            @(negedge CK);
            budget--;
            since_rsp++;
            if (busy) begin
                cyc++;
                if (cyc < 16) begin
                    tr_a[cyc] = A; tr_wen[cyc] = WEn; tr_ras[cyc] = RASn;
                    tr_cas[cyc] = CASn; tr_cs[cyc] = CSn; tr_d[cyc] = D;
                end
                if (!CASn && !cas_seen) begin
                    cas_seen = 1'b1;
                    cas_wen  = WEn;
                end
            end
            if (rsp_valid) begin
                check("rsp_expected", 64'(busy), 64'd1);
                if (busy) begin
                    check("rsp_latency", 64'(cyc), 64'(exp_lat));
                    if (cur.w) check("rdata_hold_on_write", rsp_rdata, exp_rd);
                    else       check("rdata", rsp_rdata, exp_rd);
                    last_lat  = cyc;
                    busy      = 1'b0;
                    since_rsp = 0;
                    got++;
                end
            end
            if (rq.size() > 0 && (hold || gap == 0)) begin
                req_valid = 1'b1;
                req_write = rq[0].w;
                req_addr  = rq[0].addr;
                req_wdata = rq[0].data;
                req_wstrb = rq[0].strb;
            end else begin
                req_valid = 1'b0;
                if (gap > 0) gap--;
            end
            if (req_valid && req_ready) begin
                check("accept_while_busy", 64'(busy), 64'd0);
                if (hold && got > 0) begin
`ifdef DRAM_OPEN_PAGE_EN
                    check("b2b_accept_gap", 64'(since_rsp), 64'd0);
`else
                    check("b2b_accept_gap", 64'(since_rsp), 64'd1);
`endif
                end
                cur = rq.pop_front();
                row = cur.addr[AW-1:COL_BITS];
`ifdef DRAM_OPEN_PAGE_EN
                base    = !pg_open ? 5 : ((row == pg_row) ? 3 : 6);
                pg_open = 1'b1;
                pg_row  = row;
`else
                base = 5;
`endif
                if (cur.w) begin
                    old = ref_mem.exists(cur.addr) ? ref_mem[cur.addr] : 32'h0;
                    for (int b = 0; b < 4; b++) if (cur.strb[b]) old[8*b +: 8] = cur.data[8*b +: 8];
                    ref_mem[cur.addr] = old;
                    exp_lat = base;
                end else begin
                    last_rd = ref_mem.exists(cur.addr) ? ref_mem[cur.addr] : 32'h0;
                    exp_lat = base + CAS_LAT;
                end
                exp_rd   = last_rd;
                busy     = 1'b1;
                cas_seen = 1'b0;
                cyc      = 0;
                gap      = hold ? 0 : $urandom_range(0, maxgap);
            end
        end
        req_valid = 1'b0;
        check("all_responses", 64'(got), 64'(n));
        rq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset state ----
        RSTn = 1'b0;
        repeat (3) @(negedge CK);
        check("rst_csn", CSn, 1); check("rst_rasn", RASn, 1); check("rst_casn", CASn, 1);
        check("rst_wen", WEn, 4'hF); check("rst_a", A, 0); check("rst_d", D, 0);
        check("rst_ready", req_ready, 0); check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        RSTn = 1'b1;
        @(negedge CK);
        check("ready_after_rst", req_ready, 1);

        // ---- single write: pin sequence ----
        push(1, 5, 10, 32'd10, 4'hF);
        run(0, 0);
        check("w_a_row", tr_a[1], 5); check("w_a_ras", tr_a[2], 5);
        check("w_a_col", tr_a[3], 10); check("w_a_cas", tr_a[4], 10);
        check("w_wen_col", tr_wen[3], 4'h0); check("w_wen_cas", tr_wen[4], 4'h0);
        check("w_ras_row", tr_ras[1], 1); check("w_ras_ras", tr_ras[2], 0);
        check("w_cas_col", tr_cas[3], 1); check("w_cas_cas", tr_cas[4], 0);
        check("w_cs_row", tr_cs[1], 0); check("w_d_col", tr_d[3], 10);
        check("w_lat", last_lat, 5);
`ifndef DRAM_OPEN_PAGE_EN
        @(negedge CK);
        check("idle_after_pre_ready", req_ready, 1);
        check("idle_after_pre_csn", CSn, 1);
`endif

        // ---- read back ----
        push(0, 5, 10, 32'h0, 4'h0);
        run(0, 0);
        check("r_rdata", rsp_rdata, 32'd10);
`ifndef DRAM_OPEN_PAGE_EN
        check("r_lat", last_lat, 6);
`endif

        // ---- partial byte write ----
        push(1, 5, 11, 32'h11223344, 4'hF);
        push(1, 5, 11, 32'hAABBCCDD, 4'b0011);
        push(0, 5, 11, 32'h0, 4'h0);
        run(0, 2);
        check("strobe_merge", rsp_rdata, 32'h1122CCDD);

        // ---- zero strobe write ----
        push(1, 5, 11, 32'hDEADBEEF, 4'h0);
        run(0, 0);
        check("zero_strb_wen", cas_wen, 4'hF);
        check("zero_strb_rdata_hold", rsp_rdata, 32'h1122CCDD);
        push(0, 5, 11, 32'h0, 4'h0);
        run(0, 0);
        check("zero_strb_unchanged", rsp_rdata, 32'h1122CCDD);

        // ---- back-to-back with req_valid held ----
        push(1, 5, 20, 32'hCAFE0001, 4'hF);
        push(0, 5, 20, 32'h0, 4'h0);
        push(1, 6, 21, 32'hCAFE0002, 4'hF);
        push(0, 6, 21, 32'h0, 4'h0);
        run(1, 0);
        check("b2b_last_read", rsp_rdata, 32'hCAFE0002);

        // ---- random traffic ----
        for (int i = 0; i < 40; i++)
            push($urandom_range(0, 1), $urandom_range(5, 7), $urandom_range(0, 3),
                 $urandom, 4'($urandom_range(0, 15)));
        run(0, 3);
        for (int i = 0; i < 20; i++)
            push($urandom_range(0, 1), $urandom_range(5, 7), $urandom_range(0, 3),
                 $urandom, 4'($urandom_range(0, 15)));
        run(1, 0);

        // ---- reset during WAIT ----
        req_write = 1'b0;
        req_addr  = {ROW_BITS'(5), COL_BITS'(10)};
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CK);
        check("rstw_ready", req_ready, 1);
        @(negedge CK);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && CASn; i++) @(negedge CK);
        check("rstw_reach_cas", CASn, 0);
        @(negedge CK);
        check("rstw_in_wait", {RASn, CASn, rsp_valid}, 3'b000);
        RSTn = 1'b0;
        #1;
        check("rstw_csn", CSn, 1); check("rstw_rasn", RASn, 1); check("rstw_casn", CASn, 1);
        check("rstw_wen", WEn, 4'hF); check("rstw_a", A, 0); check("rstw_d", D, 0);
        check("rstw_ready", req_ready, 0); check("rstw_rsp", rsp_valid, 0);
        check("rstw_rdata", rsp_rdata, 0);
        @(negedge CK);
        check("rstw_rsp_held", rsp_valid, 0);
        RSTn    = 1'b1;
        pg_open = 1'b0;
        last_rd = 32'h0;
        check("rstw_ready_before_edge", req_ready, 0);
        @(negedge CK);
        check("rstw_ready_after_edge", req_ready, 1);
        check("rstw_no_rsp", rsp_valid, 0);
        push(1, 5, 10, 32'h55AA55AA, 4'hF);
        run(0, 0);
        check("rstw_w_lat", last_lat, 5);

`ifdef DRAM_OPEN_PAGE_EN
        // ---- open page: row hit then row miss ----
        push(0, 5, 10, 32'h0, 4'h0);
        run(0, 0);
        check("op_hit_lat", last_lat, 3 + CAS_LAT);
        check("op_hit_no_row", tr_ras[1], 0);
        check("op_hit_col", tr_a[1], 10);
        check("op_hit_rdata", rsp_rdata, 32'h55AA55AA);
        push(0, 6, 21, 32'h0, 4'h0);
        run(0, 0);
        check("op_miss_lat", last_lat, 6 + CAS_LAT);
        check("op_miss_pre", tr_ras[1], 1);
        check("op_miss_row", tr_a[2], 6);
`else
        push(0, 5, 10, 32'h0, 4'h0);
        run(0, 0);
        check("rstw_r_rdata", rsp_rdata, 32'h55AA55AA);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter ROW_BITS, default 11, row address width.
REQ-002 SHALL have parameter COL_BITS, default 11, column address width (COL_BITS equals ROW_BITS, the shared A bus width).
REQ-003 SHALL have parameter CAS_LAT, default 1, range 1-7, cycles from CAS state to Q valid.
REQ-004 SHALL have ports as follows: CK  in  1  sole clock, all state on rising edge.
REQ-005 RSTn  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present; req_ready  out  1  request accepted when both high on an edge.
REQ-007 req_write  in  1  1=write, 0=read; req_addr  in  ROW_BITS+COL_BITS  {row,col}; req_wdata  in  32  write data; req_wstrb  in  4  byte enables.
REQ-008 rsp_valid  out  1  single-cycle completion pulse, no backpressure; rsp_rdata  out  32  read data, valid with rsp_valid on reads.
REQ-009 CSn, RASn, CASn  out  1 each; WEn  out  4; A  out  COL_BITS; D  out  32; Q  in  32  DRAM device pins.

Function
REQ-010 SHALL latch req_write/addr/wdata/wstrb on acceptance; req_ready high only in IDLE (and OPEN when DRAM_OPEN_PAGE_EN).
REQ-011 States: IDLE, ROW, RAS, COL, CAS, WAIT, PRE; each non-WAIT state lasts exactly one cycle.
REQ-012 IDLE: CSn=1, RASn=1, CASn=1, WEn=4'b1111, A=0, D=0; accept -> ROW.
REQ-013 ROW: CSn=0, A=row, RASn=1 -> RAS.
REQ-014 RAS: RASn=0, A=row -> COL.
REQ-015 COL: RASn=0, A=col; write: WEn=~wstrb, D=wdata; read: WEn=4'b1111 -> CAS.
REQ-016 CAS: RASn=0, CASn=0, A/WEn/D held from COL; write -> PRE; read -> WAIT.
REQ-017 WAIT: RASn=0, CASn=0, WEn=4'b1111; stays CAS_LAT cycles; Q registered into rsp_rdata at final WAIT edge -> PRE.
REQ-018 PRE: RASn=1, CASn=1, WEn=4'b1111, CSn=0 -> IDLE; rsp_valid=1 in PRE cycle for both reads and writes.
REQ-019 Latency (accept edge = cycle 0): write rsp_valid in cycle 5; read rsp_valid in cycle 5+CAS_LAT; next accept earliest cycle after PRE.
REQ-020 WEn all-ones during any write with req_wstrb=0 (write completes, no byte written, rsp_valid still pulses).
REQ-021 rsp_rdata holds last read value until next read completion; unchanged on writes.
REQ-022 req_valid held continuously SHALL produce back-to-back transactions with no lost or duplicated request.

Reset
REQ-023 RSTn low SHALL immediately force IDLE, CSn=RASn=CASn=1, WEn=4'b1111, A=0, D=0, req_ready=0, rsp_valid=0, rsp_rdata=0.
REQ-024 Reset mid-transaction SHALL discard the latched request; no rsp_valid for it; req_ready=1 from first edge after RSTn rises.

Configuration
REQ-025 Macro DRAM_OPEN_PAGE_EN: when defined, CAS (write) or last WAIT (read) -> OPEN instead of PRE; OPEN holds RASn=0, CASn=1, A=row, WEn=4'b1111, req_ready=1, rsp_valid pulses in first OPEN cycle.
REQ-026 With DRAM_OPEN_PAGE_EN, OPEN accept with same row -> COL (row hit, write rsp in cycle 3); different row -> PRE -> ROW; OPEN with no request stays OPEN.
REQ-027 Without DRAM_OPEN_PAGE_EN: closed-page behaviour of REQ-011..REQ-019 only; no OPEN state exists.

Verification
REQ-028 Write row=5 col=10 wdata=10 wstrb=4'hF -> A=5,5,10,10 in ROW..CAS, WEn=4'b0000 in COL/CAS, rsp_valid in cycle 5.
REQ-029 Read row=5 col=10 after REQ-028, CAS_LAT=1 -> rsp_valid cycle 6, rsp_rdata=10.
REQ-030 Write 0x11223344 wstrb=4'hF then 0xAABBCCDD wstrb=4'b0011 to row=5 col=11, read back -> rsp_rdata=0x1122CCDD.
REQ-031 req_valid held high, four alternating write/read requests -> exactly four rsp_valid pulses, reads return written data.
REQ-032 RSTn low during WAIT -> pins idle same cycle, no rsp_valid, next request completes normally.
REQ-033 DRAM_OPEN_PAGE_EN: write row=5 col=10 then read row=5 col=10 -> second skips ROW/RAS; then read row=6 -> PRE, ROW sequence, correct data.
